// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Brief    : Shared mem_* bus widths and request/response record types.
// Revision : 1.0
// ============================================================================
package mem_bus_pkg;

  localparam int MEM_AW_DEF = 16;
  localparam int MEM_DW_DEF = 32;

  typedef struct packed {
    logic                  write;
    logic [MEM_AW_DEF-1:0] addr;
    logic [MEM_DW_DEF-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic                  vld;
    logic [MEM_DW_DEF-1:0] rdata;
  } mem_rsp_t;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_lat_pipe
// Brief    : Valid/data shift register; data stages load only with valid so
//            the last stage holds the previous result between strobes.
// Revision : 1.0
// ============================================================================
module mem_lat_pipe
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int W     = MEM_DW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_data[0] <= i_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_data[DEPTH-1];

endmodule : mem_lat_pipe
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Single-request memory responder: sync-read word array, fixed read
//            latency, saturating access counters and sticky out-of-range flag.
// Revision : 1.0
// ============================================================================
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter int MEM_DW   = MEM_DW_DEF,
  parameter int DEPTH_AW = 10,
  parameter int READ_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  input  logic              clr,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              oor_err
);

  localparam int              DEPTH     = 1 << DEPTH_AW;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [MEM_DW-1:0]   r_mem [DEPTH];
  logic [DEPTH_AW-1:0] w_idx;
  logic                w_wr;
  logic                w_rd;
  logic                w_oor;
  logic                r_s1_vld;
  logic [MEM_DW-1:0]   r_s1_data;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic                r_oor;

  assign w_idx = mem_addr[DEPTH_AW-1:0];
  assign w_wr  = mem_req & mem_write;
  assign w_rd  = mem_req & ~mem_write;

  generate
    if (DEPTH_AW < MEM_AW) begin : g_oor_chk
      assign w_oor = |mem_addr[MEM_AW-1:DEPTH_AW];
    end else begin : g_oor_none
      assign w_oor = 1'b0;
    end
  endgenerate

  // Array has no reset: contents survive rst_n so committed writes persist.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd;
      if (w_rd) begin
        r_s1_data <= r_mem[w_idx];
      end
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign mem_rdata_vld = r_s1_vld;
      assign mem_rdata     = r_s1_data;
    end else begin : g_latn
      mem_lat_pipe #(
        .DEPTH (READ_LAT - 1),
        .W     (MEM_DW)
      ) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (r_s1_vld),
        .i_data (r_s1_data),
        .o_vld  (mem_rdata_vld),
        .o_data (mem_rdata)
      );
    end
  endgenerate

  // clr wins over a same-cycle access: it is neither counted nor flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_oor    <= 1'b0;
    end else if (clr) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_oor    <= 1'b0;
    end else begin
      if (w_rd && (r_rd_cnt != c_CNT_MAX)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_wr && (r_wr_cnt != c_CNT_MAX)) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (mem_req && w_oor) begin
        r_oor <= 1'b1;
      end
    end
  end

  assign rd_cnt  = r_rd_cnt;
  assign wr_cnt  = r_wr_cnt;
  assign oor_err = r_oor;

endmodule : mem_responder
`default_nettype wire
